// File: rtl/vga_sync_porch_if.sv
// Video stream bundle: companion syncs plus RGB, used on both sides of vga_sync_porch.
// master drives the stream and slave consumes it.
interface vga_sync_porch_if #(
  parameter int VIDEO_WIDTH = 3
);
  logic                   HSync;
  logic                   VSync;
  logic [VIDEO_WIDTH-1:0] Red_Video;
  logic [VIDEO_WIDTH-1:0] Grn_Video;
  logic [VIDEO_WIDTH-1:0] Blu_Video;

  modport master (output HSync, VSync, Red_Video, Grn_Video, Blu_Video);
  modport slave  (input  HSync, VSync, Red_Video, Grn_Video, Blu_Video);
endinterface

// File: rtl/vga_sync_porch.sv
// Converts active-area syncs into VGA porch/pulse timing, blanks video outside the
// visible window, and keeps syncs and video aligned through two register stages.
module vga_sync_porch #(
  parameter int VIDEO_WIDTH      = 3,
  parameter int TOTAL_COLS       = 800,
  parameter int TOTAL_ROWS       = 525,
  parameter int ACTIVE_COLS      = 640,
  parameter int ACTIVE_ROWS      = 480,
  parameter int FRONT_PORCH_HORZ = 18,
  parameter int BACK_PORCH_HORZ  = 50,
  parameter int FRONT_PORCH_VERT = 10,
  parameter int BACK_PORCH_VERT  = 33
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  vga_sync_porch_if.slave  i_Vid,
  vga_sync_porch_if.master o_Vid,
  output logic             o_Locked
);

  localparam int COL_W = $clog2(TOTAL_COLS);
  localparam int ROW_W = $clog2(TOTAL_ROWS);

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(TOTAL_COLS - 1);
  localparam logic [COL_W-1:0] COL_ACTIVE = COL_W'(ACTIVE_COLS);
  localparam logic [COL_W-1:0] HS_FIRST   = COL_W'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam logic [COL_W-1:0] HS_LAST    = COL_W'(TOTAL_COLS - BACK_PORCH_HORZ - 1);

  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ACTIVE = ROW_W'(ACTIVE_ROWS);
  localparam logic [ROW_W-1:0] VS_FIRST   = ROW_W'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam logic [ROW_W-1:0] VS_LAST    = ROW_W'(TOTAL_ROWS - BACK_PORCH_VERT - 1);

  logic [COL_W-1:0]       r_Col;
  logic [ROW_W-1:0]       r_Row;
  logic                   r_VSync_d;
  logic [VIDEO_WIDTH-1:0] r_Red;
  logic [VIDEO_WIDTH-1:0] r_Grn;
  logic [VIDEO_WIDTH-1:0] r_Blu;

  logic frame_start;
  logic hs_pulse;
  logic vs_pulse;
  logic active_area;

  // The generator's horizontal companion sync carries no information we need.
  logic unused_hsync;
  assign unused_hsync = i_Vid.HSync;

  assign frame_start = i_Vid.VSync & ~r_VSync_d;

  // Stage 1: position counters and the pixel they describe.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Col     <= '0;
      r_Row     <= '0;
      r_VSync_d <= 1'b1;
      o_Locked  <= 1'b0;
      r_Red     <= '0;
      r_Grn     <= '0;
      r_Blu     <= '0;
    end else begin
      r_VSync_d <= i_Vid.VSync;
      r_Red     <= i_Vid.Red_Video;
      r_Grn     <= i_Vid.Grn_Video;
      r_Blu     <= i_Vid.Blu_Video;
      if (frame_start) begin
        r_Col    <= '0;
        r_Row    <= '0;
        o_Locked <= 1'b1;
      end else if (r_Col == COL_LAST) begin
        r_Col <= '0;
        r_Row <= (r_Row == ROW_LAST) ? '0 : r_Row + 1'b1;
      end else begin
        r_Col <= r_Col + 1'b1;
      end
    end
  end

  always_comb begin
    hs_pulse    = (r_Col >= HS_FIRST) && (r_Col <= HS_LAST);
    vs_pulse    = (r_Row >= VS_FIRST) && (r_Row <= VS_LAST);
    active_area = (r_Col < COL_ACTIVE) && (r_Row < ROW_ACTIVE);
  end

  // Stage 2: registered VGA outputs, held idle until the first frame start.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Vid.HSync     <= 1'b1;
      o_Vid.VSync     <= 1'b1;
      o_Vid.Red_Video <= '0;
      o_Vid.Grn_Video <= '0;
      o_Vid.Blu_Video <= '0;
    end else if (!o_Locked) begin
      o_Vid.HSync     <= 1'b1;
      o_Vid.VSync     <= 1'b1;
      o_Vid.Red_Video <= '0;
      o_Vid.Grn_Video <= '0;
      o_Vid.Blu_Video <= '0;
    end else begin
      o_Vid.HSync     <= ~hs_pulse;
      o_Vid.VSync     <= ~vs_pulse;
      o_Vid.Red_Video <= active_area ? r_Red : '0;
      o_Vid.Grn_Video <= active_area ? r_Grn : '0;
      o_Vid.Blu_Video <= active_area ? r_Blu : '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_porch.sv
// Randomized bench for vga_sync_porch on a reduced 50x30 raster, checked every cycle
// against a linear pixel-index model plus literal timing expectations.
module tb_vga_sync_porch;

  localparam int VW  = 3;
  localparam int TC  = 50;
  localparam int TR  = 30;
  localparam int AC  = 32;
  localparam int AR  = 20;
  localparam int FPH = 4;
  localparam int BPH = 6;
  localparam int FPV = 2;
  localparam int BPV = 5;
  localparam int FRAME = TC * TR;
  localparam int PW    = 3 * VW + 2;

  // Hand-computed for this raster: hsync low cols 36..43, vsync low rows 22..24.
  localparam int HS_FIRST_LIT = 36;
  localparam int HS_LEN_LIT   = 8;
  localparam int VS_FIRST_LIT = 1100;
  localparam int VS_LEN_LIT   = 150;

  logic i_Clk   = 1'b0;
  logic i_Rst_L = 1'b0;
  logic o_Locked;

  always #5 i_Clk = ~i_Clk;

  vga_sync_porch_if #(.VIDEO_WIDTH(VW)) vin ();
  vga_sync_porch_if #(.VIDEO_WIDTH(VW)) vout ();

  vga_sync_porch #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .FRONT_PORCH_HORZ(FPH), .BACK_PORCH_HORZ(BPH),
    .FRONT_PORCH_VERT(FPV), .BACK_PORCH_VERT(BPV)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Vid   (vin),
    .o_Vid   (vout),
    .o_Locked(o_Locked)
  );

  int   vectors = 0;
  int   errors  = 0;
  logic chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: p is the linear pixel index since the last frame start (mod frame size).
  logic          m_prev;
  logic          m_locked;
  int            m_p;
  logic [PW-1:0] m_pend;
  logic [PW-1:0] m_exp;
  logic          m_fs;
  int            m_np;

  localparam logic [PW-1:0] IDLE = {2'b11, {(PW-2){1'b0}}};

  function automatic logic [PW-1:0] pix(input logic lk, input int p, input logic [3*VW-1:0] rgb);
    int c;
    int r;
    logic hs, vs;
    c = p % TC;
    r = p / TC;
    if (!lk) return IDLE;
    hs = !(c >= AC + FPH && c < TC - BPH);
    vs = !(r >= AR + FPV && r < TR - BPV);
    return {hs, vs, (c < AC && r < AR) ? rgb : {(3*VW){1'b0}}};
  endfunction

  assign m_fs = vin.VSync && !m_prev;
  assign m_np = m_fs ? 0 : (m_p + 1) % FRAME;

  always @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      m_prev   <= 1'b1;
      m_locked <= 1'b0;
      m_p      <= 0;
      m_pend   <= IDLE;
      m_exp    <= IDLE;
    end else begin
      m_prev   <= vin.VSync;
      m_locked <= m_locked | m_fs;
      m_p      <= m_np;
      m_pend   <= pix(m_locked | m_fs, m_np, {vin.Red_Video, vin.Grn_Video, vin.Blu_Video});
      m_exp    <= m_pend;
    end
  end

  always @(negedge i_Clk) begin
    if (chk_en) begin
      check("outputs", 32'({vout.HSync, vout.VSync, vout.Red_Video, vout.Grn_Video, vout.Blu_Video}),
            32'(m_exp));
      check("locked", 32'(o_Locked), 32'(m_locked));
    end
  end

  // Generator emulation: gcol/grow is the next pixel to present.
  int   gcol = 0;
  int   grow = 0;
  logic noise_en     = 1'b0;
  logic white_origin = 1'b0;
  logic drove_origin = 1'b0;

  task automatic rand_rgb();
    vin.Red_Video = VW'($urandom);
    vin.Grn_Video = VW'($urandom);
    vin.Blu_Video = VW'($urandom);
  endtask

  task automatic step();
    @(negedge i_Clk);
    drove_origin = (gcol == 0 && grow == 0);
    vin.VSync = (grow < AR);
    vin.HSync = (gcol < AC) ^ (noise_en && ($urandom_range(0, 1) == 1));
    if (white_origin && drove_origin) begin
      vin.Red_Video = '1;
      vin.Grn_Video = '1;
      vin.Blu_Video = '1;
    end else begin
      rand_rgb();
    end
    if (gcol == TC - 1) begin
      gcol = 0;
      grow = (grow == TR - 1) ? 0 : grow + 1;
    end else begin
      gcol++;
    end
  endtask

  task automatic resync();
    @(negedge i_Clk);
    vin.VSync = 1'b0;
    vin.HSync = 1'b0;
    rand_rgb();
    drove_origin = 1'b0;
    gcol = 0;
    grow = 0;
  endtask

  task automatic run_until_origin(input int limit);
    int n;
    n = 0;
    step();
    while (!drove_origin && n < limit) begin
      step();
      n++;
    end
    check("origin_reached", 32'(drove_origin), 32'd1);
  endtask

  task automatic reset_pulse(input int len);
    #2 i_Rst_L = 1'b0;
    repeat (len) step();
    #2 i_Rst_L = 1'b1;
  endtask

  initial begin
    int hs_first, hs_len, vs_first, vs_len, n;
    vin.HSync = 1'b0;
    vin.VSync = 1'b1;
    vin.Red_Video = '0;
    vin.Grn_Video = '0;
    vin.Blu_Video = '0;

    @(posedge i_Clk);
    chk_en = 1'b1;
    repeat (4) @(posedge i_Clk);
    @(negedge i_Clk);
    check("reset_state", 32'({vout.HSync, vout.VSync, vout.Red_Video, vout.Grn_Video, vout.Blu_Video}),
          32'(IDLE));
    check("reset_locked", 32'(o_Locked), 32'd0);

    // VSync held high across release must not lock.
    i_Rst_L = 1'b1;
    repeat (40) begin
      @(negedge i_Clk);
      vin.VSync = 1'b1;
      rand_rgb();
    end
    check("no_lock_vsync_high", 32'(o_Locked), 32'd0);
    check("idle_hsync", 32'(vout.HSync), 32'd1);

    // Stream starts in vertical blanking, first frame start at the origin pixel.
    noise_en     = 1'b1;
    white_origin = 1'b1;
    grow = AR + 2;
    gcol = 0;
    run_until_origin(2 * FRAME);
    check("prelock", 32'(o_Locked), 32'd0);
    step();
    check("lock_edge", 32'(o_Locked), 32'd1);
    check("lock_still_idle", 32'({vout.HSync, vout.VSync, vout.Red_Video, vout.Grn_Video, vout.Blu_Video}),
          32'(IDLE));
    step();
    check("white_latency", 32'({vout.HSync, vout.VSync, vout.Red_Video, vout.Grn_Video, vout.Blu_Video}),
          32'({2'b11, {(3*VW){1'b1}}}));
    white_origin = 1'b0;

    hs_first = -1; hs_len = 0; vs_first = -1; vs_len = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (vout.HSync == 1'b0 && i < TC) begin
        if (hs_first < 0) hs_first = i;
        hs_len++;
      end
      if (vout.VSync == 1'b0) begin
        if (vs_first < 0) vs_first = i;
        vs_len++;
      end
      step();
    end
    check("hs_fall_offset", 32'(hs_first), 32'(HS_FIRST_LIT));
    check("hs_low_len", 32'(hs_len), 32'(HS_LEN_LIT));
    check("vs_fall_offset", 32'(vs_first), 32'(VS_FIRST_LIT));
    check("vs_low_len", 32'(vs_len), 32'(VS_LEN_LIT));

    // Mid-frame resync at row 10, col 15.
    n = 0;
    while (!(grow == 10 && gcol == 15) && n < 2 * FRAME) begin
      step();
      n++;
    end
    resync();
    step();
    step();
    step();
    hs_first = -1;
    for (int i = 0; i < TC; i++) begin
      if (vout.HSync == 1'b0 && hs_first < 0) hs_first = i;
      step();
    end
    check("resync_hs_fall", 32'(hs_first), 32'(HS_FIRST_LIT));

    // Async reset during an HSync low period.
    n = 0;
    while (vout.HSync !== 1'b0 && n < 2 * TC) begin
      step();
      n++;
    end
    check("hs_low_seen", 32'(vout.HSync), 32'd0);
    #2 i_Rst_L = 1'b0;
    #1;
    check("async_hs", 32'(vout.HSync), 32'd1);
    check("async_locked", 32'(o_Locked), 32'd0);
    repeat (3) step();
    #2 i_Rst_L = 1'b1;
    n = 0;
    while (o_Locked !== 1'b1 && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("relock", 32'(o_Locked), 32'd1);

    // Random tail: free running with occasional resyncs and reset pulses.
    repeat (8) begin
      repeat ($urandom_range(50, 1500)) step();
      case ($urandom_range(0, 2))
        0: resync();
        1: reset_pulse($urandom_range(1, 4));
        default: step();
      endcase
    end
    repeat (2 * FRAME) step();
    check("final_locked", 32'(o_Locked), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
